// File: rtl/id_predecode_buf.sv
// Two-entry decode buffer between fetch and identify. Each instruction is predecoded
// into one-hot opcode fields when it is pushed, so identify sees decoded fields directly.
module id_predecode_buf #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             if_valid_i,
    input  logic [PC_W-1:0]  if_pc_i,
    input  logic [31:0]      if_inst_i,
    output logic             id_allowin_o,
    output logic             od_valid_o,
    input  logic             od_allowin_i,
    output logic [PC_W-1:0]  od_pc_o,
    output logic [147:0]     od_to_ibus_o,
    output logic [1:0]       count_o
);
    localparam int EW = PC_W + 148;

    logic [EW-1:0] mem [DEPTH];
    logic [1:0]    count;
    logic          wptr, rptr;
    logic          push, pop;

    function automatic logic [147:0] predecode(input logic [31:0] inst);
        logic [63:0] d_31_26;
        logic [15:0] d_25_22;
        logic [3:0]  d_21_20;
        logic [31:0] d_19_15;
        d_31_26 = 64'd1 << inst[31:26];
        d_25_22 = 16'd1 << inst[25:22];
        d_21_20 = 4'd1 << inst[21:20];
        d_19_15 = 32'd1 << inst[19:15];
        return {d_31_26, d_25_22, d_21_20, d_19_15, inst};
    endfunction

    // Handshake flags come only from registered occupancy, never from od_allowin_i.
    assign id_allowin_o = (count != 2'd2);
    assign od_valid_o   = (count != 2'd0);
    assign count_o      = count;

    assign push = if_valid_i & id_allowin_o & ~flush_i;
    assign pop  = od_valid_o & od_allowin_i & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else if (flush_i) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage is not reset; stale contents are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {if_pc_i, predecode(if_inst_i)};
    end

    assign od_pc_o      = od_valid_o ? mem[rptr][EW-1:148] : '0;
    assign od_to_ibus_o = od_valid_o ? mem[rptr][147:0]    : '0;

endmodule

// File: tb/tb_id_predecode_buf.sv
// Directed bench for id_predecode_buf: the driver queues expected entries on each
// accepted push, and a negedge monitor checks every head the identify stage consumes.
module tb_id_predecode_buf;
    localparam int PC_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_i = 1'b0;
    logic             if_valid_i = 1'b0;
    logic [PC_W-1:0]  if_pc_i = '0;
    logic [31:0]      if_inst_i = '0;
    logic             id_allowin_o;
    logic             od_valid_o;
    logic             od_allowin_i = 1'b0;
    logic [PC_W-1:0]  od_pc_o;
    logic [147:0]     od_to_ibus_o;
    logic [1:0]       count_o;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    id_predecode_buf #(.PC_W(PC_W), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
        .id_allowin_o(id_allowin_o), .od_valid_o(od_valid_o),
        .od_allowin_i(od_allowin_i), .od_pc_o(od_pc_o),
        .od_to_ibus_o(od_to_ibus_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // Reference one-hot built by scanning, independent of any shift formulation.
    function automatic logic [147:0] ref_bus(input logic [31:0] inst);
        logic [63:0] a; logic [15:0] b; logic [3:0] c; logic [31:0] d;
        a = '0; b = '0; c = '0; d = '0;
        for (int i = 0; i < 64; i++) if (i == int'(inst[31:26])) a[i] = 1'b1;
        for (int i = 0; i < 16; i++) if (i == int'(inst[25:22])) b[i] = 1'b1;
        for (int i = 0; i < 4; i++)  if (i == int'(inst[21:20])) c[i] = 1'b1;
        for (int i = 0; i < 32; i++) if (i == int'(inst[19:15])) d[i] = 1'b1;
        return {a, b, c, d, inst};
    endfunction

    task automatic check(input string name, input logic [147:0] act, input logic [147:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a head consumed at the coming edge must match the oldest queued entry.
    always @(negedge clk) begin
        if (rst_n && od_valid_o && od_allowin_i && !flush_i) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got pc %h with nothing expected", od_pc_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (od_pc_o !== e.pc || od_to_ibus_o !== ref_bus(e.inst)) begin
                    n_err++;
                    $display("FAIL pop_order: got pc %h bus %h expected pc %h bus %h",
                             od_pc_o, od_to_ibus_o, e.pc, ref_bus(e.inst));
                end
            end
        end
    end

    // One cycle: drive inputs, record expected capture, advance past the edge.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic oa, input logic fl);
        if_valid_i = iv; if_pc_i = pc; if_inst_i = inst; od_allowin_i = oa; flush_i = fl;
        if (fl) sb.delete();
        else if (iv && id_allowin_o) sb.push_back('{pc: pc, inst: inst});
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drained_count", 148'(count_o), 148'(0));
    endtask

    initial begin
        #2;
        check("rst_count",   148'(count_o),      148'(0));
        check("rst_allowin", 148'(id_allowin_o), 148'(1));
        check("rst_valid",   148'(od_valid_o),   148'(0));
        check("rst_bus",     od_to_ibus_o,       148'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();

        // add.w r1,r2,r3 through an empty buffer, consumed the cycle after
        step(1'b1, 32'h1c000000, 32'h00100C41, 1'b1, 1'b0);
        check("add_valid", 148'(od_valid_o), 148'(1));
        check("add_pc",    148'(od_pc_o),    148'(32'h1c000000));
        check("add_bus",   od_to_ibus_o,     {64'h1, 16'h1, 4'h2, 32'h1, 32'h00100C41});
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("add_popped", 148'(count_o), 148'(0));

        // three pushes against a stalled identify stage: third dropped
        step(1'b1, 32'h0, 32'h02800C21, 1'b0, 1'b0);
        step(1'b1, 32'h4, 32'h28C00081, 1'b0, 1'b0);
        check("full_allowin", 148'(id_allowin_o), 148'(0));
        step(1'b1, 32'h8, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("full_count", 148'(count_o), 148'(2));
        check("full_head",  148'(od_pc_o),  148'(32'h0));
        drain();

        // full with push+pop at one edge: only the pop happens
        step(1'b1, 32'h10, 32'h0000_0000, 1'b0, 1'b0);
        step(1'b1, 32'h14, 32'h4C00_0020, 1'b0, 1'b0);
        step(1'b1, 32'h20, 32'h5555_5555, 1'b1, 1'b0);
        check("full_pushpop_count", 148'(count_o), 148'(1));
        step(1'b1, 32'h24, 32'hAAAA_AAAA, 1'b0, 1'b0);
        check("refill_count", 148'(count_o), 148'(2));
        drain();

        // count=1, simultaneous push of lu12i.w and pop
        step(1'b1, 32'h2c, 32'h0380_0000, 1'b0, 1'b0);
        step(1'b1, 32'h30, 32'h1400_0021, 1'b1, 1'b0);
        check("pp_count",   148'(count_o),              148'(1));
        check("pp_op31_26", 148'(od_to_ibus_o[147:84]), 148'(64'h20));
        check("pp_inst25",  148'(od_to_ibus_o[25]),     148'(0));
        check("pp_pc",      148'(od_pc_o),              148'(32'h30));
        drain();

        // flush beats push and pop
        step(1'b1, 32'h38, 32'h1234_5678, 1'b0, 1'b0);
        step(1'b1, 32'h3c, 32'h8765_4321, 1'b0, 1'b0);
        step(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check("flush_count", 148'(count_o),    148'(0));
        check("flush_valid", 148'(od_valid_o), 148'(0));
        check("flush_bus",   od_to_ibus_o,     148'(0));
        check("flush_pc",    148'(od_pc_o),    148'(0));
        step(1'b1, 32'h44, 32'h0010_0C41, 1'b0, 1'b0);
        check("postflush_pc", 148'(od_pc_o), 148'(32'h44));
        drain();

        // asynchronous reset between edges while full
        step(1'b1, 32'h50, 32'h1111_1111, 1'b0, 1'b0);
        step(1'b1, 32'h54, 32'h2222_2222, 1'b0, 1'b0);
        if_valid_i = 1'b0; od_allowin_i = 1'b0;
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_count",   148'(count_o),      148'(0));
        check("arst_allowin", 148'(id_allowin_o), 148'(1));
        check("arst_valid",   148'(od_valid_o),   148'(0));
        check("arst_bus",     od_to_ibus_o,       148'(0));
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 32'h60, 32'h0280_0421, 1'b0, 1'b0);
        check("postrst_count", 148'(count_o), 148'(1));
        check("postrst_pc",    148'(od_pc_o), 148'(32'h60));
        drain();

        check("sb_empty", 148'(sb.size()), 148'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
